// File: rtl/regfile_scan_ctrl.sv
// regfile_scan_ctrl: walks a register file's debug read port and streams
// each register out as an (address, data) word over a valid/ready interface.
module regfile_scan_ctrl #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d, done_q, done_d;
  logic              last;
  assign last = idx_q == LAST;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d = FETCH;
          idx_d   = '0;
        end
        // rf_data has had the whole FETCH cycle to settle on idx_q
        FETCH: begin
          data_d  = rf_data_i;
          addr_d  = idx_q;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: if (valid_q && out_ready_i) begin
          valid_d = 1'b0;
          done_d  = last;
          idx_d   = last ? '0 : idx_q + 1'b1;
          state_d = (last && !CONTINUOUS) ? IDLE : FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end
  assign rf_addr_o   = idx_q;
  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;
  assign busy_o      = state_q != IDLE;
  assign done_o      = done_q;
endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// tb_regfile_scan_ctrl: directed bench for one-shot and continuous scan controllers
// against a model register file holding reg[i]=i except reg[29]=0xFC.
module tb_regfile_scan_ctrl;
  logic        clk, rst_n;
  logic        start, abort, ready, valid, busy, done;
  logic [4:0]  rf_addr, out_addr;
  logic [31:0] rf_data, out_data;
  logic        start_c, abort_c, ready_c, valid_c, busy_c, done_c;
  logic [4:0]  rf_addr_c, out_addr_c;
  logic [31:0] rf_data_c, out_data_c;
  int checks, errors;

  regfile_scan_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .rf_addr_o(rf_addr), .rf_data_i(rf_data), .out_valid_o(valid),
    .out_ready_i(ready), .out_addr_o(out_addr), .out_data_o(out_data),
    .busy_o(busy), .done_o(done)
  );
  regfile_scan_ctrl #(.CONTINUOUS(1'b1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .abort_i(abort_c),
    .rf_addr_o(rf_addr_c), .rf_data_i(rf_data_c), .out_valid_o(valid_c),
    .out_ready_i(ready_c), .out_addr_o(out_addr_c), .out_data_o(out_data_c),
    .busy_o(busy_c), .done_o(done_c)
  );

  function automatic logic [31:0] expv(int i);
    return (i == 29) ? 32'hFC : 32'(i);
  endfunction

  assign rf_data   = expv(int'(rf_addr));
  assign rf_data_c = expv(int'(rf_addr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({valid, busy, done, rf_addr, out_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b b=%0b d=%0b ra=%0d oa=%0d od=%0h required all 0", valid, busy, done, rf_addr, out_addr, out_data);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%0b valid=%0b required 0 0", busy, valid);
    end
  endtask

  task automatic test_full_scan();
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || out_addr !== 5'(i) || out_data !== expv(i) || rf_addr !== 5'(i)) begin
        errors++;
        $display("FAIL full_word%0d: got v=%0b a=%0d d=%0h ra=%0d required v=1 a=%0d d=%0h ra=%0d", i, valid, out_addr, out_data, rf_addr, i, expv(i), i);
      end
      step();
      checks++;
      if (valid !== 1'b0 || done !== (i == 31) || busy !== (i != 31)) begin
        errors++;
        $display("FAIL full_hs%0d: got v=%0b done=%0b busy=%0b required v=0 done=%0b busy=%0b", i, valid, done, busy, i == 31, i != 31);
      end
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_after: got done=%0b busy=%0b required 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      step();
    end
    step();
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (valid !== 1'b1 || out_addr !== 5'd3 || out_data !== 32'd3 || rf_addr !== 5'd3) begin
        errors++;
        $display("FAIL stall%0d: got v=%0b a=%0d d=%0h ra=%0d required 1 3 3 3", k, valid, out_addr, out_data, rf_addr);
      end
      step();
    end
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd3 || out_data !== 32'd3) begin
      errors++;
      $display("FAIL stall_end: got v=%0b a=%0d d=%0h required 1 3 3", valid, out_addr, out_data);
    end
    ready = 1'b1;
    step();
    checks++;
    if (valid !== 1'b0 || rf_addr !== 5'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%0b ra=%0d busy=%0b required 0 4 1", valid, rf_addr, busy);
    end
    step();
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd4 || out_data !== 32'd4) begin
      errors++;
      $display("FAIL stall_next: got v=%0b a=%0d d=%0h required 1 4 4", valid, out_addr, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      step();
    end
    step();
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd10) begin
      errors++;
      $display("FAIL abort_pre: got v=%0b a=%0d required 1 10", valid, out_addr);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle%0d: got v=%0b busy=%0b done=%0b required 0 0 0", k, valid, busy, done);
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || rf_addr !== 5'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: got busy=%0b ra=%0d v=%0b required 1 0 0", busy, rf_addr, valid);
    end
    step();
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL abort_word0: got v=%0b a=%0d d=%0h required 1 0 0", valid, out_addr, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      step();
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || rf_addr !== 5'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: got v=%0b ra=%0d busy=%0b required 0 6 1", valid, rf_addr, busy);
    end
    step();
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd6 || out_data !== 32'd6) begin
      errors++;
      $display("FAIL restart_word6: got v=%0b a=%0d d=%0h required 1 6 6", valid, out_addr, out_data);
    end
    abort = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL start_abort: got busy=%0b v=%0b required 0 0", busy, valid);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_hold: got busy=%0b required 0", busy);
    end
  endtask

  task automatic test_continuous();
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) begin
        step();
        checks++;
        if (valid_c !== 1'b1 || out_addr_c !== 5'(i) || out_data_c !== expv(i)) begin
          errors++;
          $display("FAIL cont_p%0d_word%0d: got v=%0b a=%0d d=%0h required 1 %0d %0h", p, i, valid_c, out_addr_c, out_data_c, i, expv(i));
        end
        step();
        checks++;
        if (valid_c !== 1'b0 || done_c !== (i == 31) || busy_c !== 1'b1 || rf_addr_c !== 5'((i + 1) % 32)) begin
          errors++;
          $display("FAIL cont_p%0d_hs%0d: got v=%0b done=%0b busy=%0b ra=%0d required 0 %0b 1 %0d", p, i, valid_c, done_c, busy_c, rf_addr_c, i == 31, (i + 1) % 32);
        end
      end
    end
    step();
    checks++;
    if (valid_c !== 1'b1 || out_addr_c !== 5'd0 || done_c !== 1'b0) begin
      errors++;
      $display("FAIL cont_wrap: got v=%0b a=%0d done=%0b required 1 0 0", valid_c, out_addr_c, done_c);
    end
    abort_c = 1'b1;
    step();
    abort_c = 1'b0;
    checks++;
    if (busy_c !== 1'b0) begin
      errors++;
      $display("FAIL cont_abort: got busy=%0b required 0", busy_c);
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_fetch: got busy=%0b v=%0b required 1 0", busy, valid);
    end
    step();
    step();
    #2;
    checks++;
    if (rf_addr !== 5'd1 || out_data !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre: got ra=%0d busy=%0b required 1 1", rf_addr, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, busy, done, rf_addr, out_addr, out_data} !== '0) begin
      errors++;
      $display("FAIL ar_immediate: got v=%0b b=%0b d=%0b ra=%0d oa=%0d od=%0h required all 0", valid, busy, done, rf_addr, out_addr, out_data);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL ar_idle%0d: got busy=%0b done=%0b v=%0b required 0 0 0", k, busy, done, valid);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (valid !== 1'b1 || out_addr !== 5'd0 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL ar_restart: got v=%0b a=%0d d=%0h required 1 0 0", valid, out_addr, out_data);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    {start, abort, ready, start_c, abort_c} = '0;
    ready_c = 1'b1;
    test_reset();
    test_full_scan();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_continuous();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scan_ctrl.md
REGFILE_SCAN_CTRL -- requirements
Module: regfile_scan_ctrl

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 32, number of registers scanned (addresses 0..NUM_REGS-1).
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width.
REQ-003 SHALL provide parameter DATA_W, default 32, register data width.
REQ-004 SHALL provide parameter CONTINUOUS, default 0; 1 = restart the scan from address 0 after the last register.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port start  input  1  request a scan; sampled only in IDLE.
REQ-008 SHALL have port abort  input  1  synchronous scan cancel.
REQ-009 SHALL have port rf_addr  output  ADDR_W  register-file debug read address, driven from a register.
REQ-010 SHALL have port rf_data  input  DATA_W  register-file debug read data, valid one cycle after rf_addr changes.
REQ-011 SHALL have port out_valid  output  1  out_addr/out_data hold a captured register.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the word when out_valid=1.
REQ-013 SHALL have port out_addr  output  ADDR_W  address of the captured register.
REQ-014 SHALL have port out_data  output  DATA_W  captured register value.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a full pass completes.

Function
REQ-017 SHALL implement three states: IDLE, FETCH, PRESENT.
REQ-018 IDLE: when start=1 and abort=0 at an edge SHALL go to FETCH with scan index = 0 and rf_addr = 0.
REQ-019 FETCH SHALL last exactly one cycle; on exit SHALL capture rf_data into out_data, copy the index into out_addr, set out_valid=1, and go to PRESENT.
REQ-020 PRESENT SHALL hold out_valid, out_addr and out_data stable while out_ready=0.
REQ-021 PRESENT: on an edge with out_valid=1 and out_ready=1 and index < NUM_REGS-1, SHALL clear out_valid, increment the index and rf_addr, and go to FETCH.
REQ-022 PRESENT: on handshake with index = NUM_REGS-1, SHALL clear out_valid and pulse done for exactly one cycle; with CONTINUOUS=0 SHALL go to IDLE; with CONTINUOUS=1 SHALL wrap the index and rf_addr to 0 and go to FETCH.
REQ-023 With out_ready held at 1, a full pass SHALL take exactly 2*NUM_REGS cycles from start acceptance to the done pulse: first out_valid visible after edge k+1, done visible after edge k+2*NUM_REGS.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT restart or disturb the scan.
REQ-025 abort=1 in any state SHALL force IDLE at the next edge, with out_valid=0 and done=0 and no partial word emitted; abort SHALL take priority over start and over a handshake in the same cycle.
REQ-026 rf_addr SHALL never exceed NUM_REGS-1, and the index SHALL wrap modulo NUM_REGS without overflow.
REQ-027 out_addr SHALL always equal the rf_addr that was in effect during the FETCH cycle that captured out_data.
REQ-028 rf_addr SHALL remain constant from entry to FETCH until the handshake that leaves PRESENT.

Reset
REQ-029 While reset=0, the block SHALL force state IDLE, index 0, rf_addr 0, out_valid 0, out_addr 0, out_data 0, busy 0, done 0 asynchronously.
REQ-030 Reset asserted mid-scan SHALL discard the scan with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-031 Bench SHALL cover: model register file with reg[i]=i except reg[29]=0xFC; start pulse with out_ready=1 -> 32 words (0,0)..(31,31) with (29,0xFC), done after exactly 64 cycles, busy low the next cycle.
REQ-032 Bench SHALL cover: out_ready held 0 for 5 cycles on word 3 -> out_valid/out_addr=3/out_data=3 stable for those cycles, rf_addr=3 throughout, and no words skipped or duplicated.
REQ-033 Bench SHALL cover: abort asserted while out_addr=10 is presented -> IDLE next cycle, out_valid=0, done never pulses; a new start then begins again at address 0.
REQ-034 Bench SHALL cover: start re-pulsed at word 5, and start plus abort together in IDLE -> the first scan is unaffected; the simultaneous case stays in IDLE.
REQ-035 Bench SHALL cover: CONTINUOUS=1 -> after out_addr=31 the next word is address 0, done pulses once per pass, and busy stays 1.
REQ-036 Bench SHALL cover: reset driven 0 asynchronously (between edges) during FETCH -> all outputs 0 immediately, no done pulse, and the block stays idle after release until start.
